collatz_pin_responder: RTL and testbench

- Pin-level responder behind the `tt_um_rtfb_collatz` top-level pins; it is the chip-side end of the protocol the host bench drives.
- Accepts a start value byte-by-byte on `ui_in` under strobes on `uio_in`.
- Runs an iterative Collatz engine, one step per clock.
- Returns the step count and peak value byte-by-byte on `uo_out`, with status flags on `uio_out`.

---
 rtl/collatz_pin_responder.sv | 159 +++++++++++++++
 tb/tb_collatz_pin_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_pin_responder.sv
// Chip-side Collatz responder: byte-wise load, one Collatz step per clock,
// byte-wise readout of {peak, steps} with status flags on uio_out.
module collatz_pin_responder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEPW = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned NB = (WIDTH + STEPW) / 8;
    localparam int unsigned PW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     value_q, value_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [WIDTH-1:0]     peak_q, peak_d;
    logic [STEPW-1:0]     steps_q, steps_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 ovf_q, ovf_d;
    logic                 sat_q, sat_d;
    logic [2:0]           prev_q;

    logic                 wr_edge, start_edge, rd_edge;
    logic [WIDTH+1:0]     t3;
    logic                 t_ovf;
    logic [STEPW-1:0]     steps_inc;
    logic                 steps_at_max;
    logic [WIDTH+STEPW-1:0] result;
    logic                 busy, done;
    logic                 unused_uio_hi;

    assign unused_uio_hi = &{1'b0, uio_in[7:3]};

    assign wr_edge    = uio_in[0] & ~prev_q[0] & ena;
    assign start_edge = uio_in[1] & ~prev_q[1] & ena;
    assign rd_edge    = uio_in[2] & ~prev_q[2] & ena;

    // 3n+1 as n + 2n + 1 with two guard bits to detect overflow
    assign t3    = {2'b00, n_q} + {1'b0, n_q, 1'b0} + (WIDTH+2)'(1);
    assign t_ovf = |t3[WIDTH+1:WIDTH];

    assign steps_inc    = (steps_q == '1) ? steps_q : steps_q + STEPW'(1);
    assign steps_at_max = (steps_inc == '1);

    assign result = {peak_q, steps_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            value_q  <= '0;
            n_q      <= '0;
            peak_q   <= '0;
            steps_q  <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            sat_q    <= 1'b0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            n_q      <= n_d;
            peak_q   <= peak_d;
            steps_q  <= steps_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            sat_q    <= sat_d;
            prev_q   <= uio_in[2:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    state_d = (value_q == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (n_q == WIDTH'(1)) begin
                    state_d = S_DONE;
                end else if (n_q[0] && t_ovf) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        value_d  = value_q;
        n_d      = n_q;
        peak_d   = peak_q;
        steps_d  = steps_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        sat_d    = sat_q;

        if (rd_edge) begin
            rd_ptr_d = (rd_ptr_q == PW'(NB - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        if (state_q == S_RUN) begin
            if (n_q != WIDTH'(1)) begin
                if (!n_q[0]) begin
                    n_d     = n_q >> 1;
                    steps_d = steps_inc;
                    sat_d   = sat_q | steps_at_max;
                end else if (t_ovf) begin
                    ovf_d = 1'b1;
                end else begin
                    n_d     = t3[WIDTH-1:0];
                    steps_d = steps_inc;
                    sat_d   = sat_q | steps_at_max;
                    if (t3[WIDTH-1:0] > peak_q) begin
                        peak_d = t3[WIDTH-1:0];
                    end
                end
            end
        end else if (start_edge) begin
            // start outranks a coincident wr and captures the pre-write value
            n_d      = value_q;
            peak_d   = value_q;
            steps_d  = '0;
            rd_ptr_d = '0;
            ovf_d    = (value_q == '0);
            sat_d    = 1'b0;
        end else if (wr_edge) begin
            value_d = (value_q << 8) | WIDTH'(ui_in);
        end
    end

    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        uio_out = {busy, done, ovf_q, sat_q, 4'b0000};
        uio_oe  = 8'b1111_0000;
        uo_out  = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (rd_ptr_q == PW'(i)) begin
                uo_out = result[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_collatz_pin_responder.sv
// Randomised self-checking bench for collatz_pin_responder against a
// plain-arithmetic Collatz reference model.
module tb_collatz_pin_responder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned STEPW = 16;
    localparam int unsigned NB    = (WIDTH + STEPW) / 8;
    localparam int          LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    collatz_pin_responder #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    function automatic void ref_model(input int unsigned v, output int unsigned steps,
                                      output int unsigned peak, output bit ovf,
                                      output int unsigned busy);
        longint unsigned n;
        longint unsigned t;
        steps = 0;
        peak  = v;
        ovf   = 1'b0;
        if (v == 0) begin
            ovf  = 1'b1;
            busy = 0;
            return;
        end
        n = v;
        while (n != 1) begin
            if (n % 2 == 0) begin
                n = n / 2;
                steps++;
            end else begin
                t = 3 * n + 1;
                if (t > 65535) begin
                    ovf = 1'b1;
                    break;
                end
                n = t;
                steps++;
                if (t > peak) peak = int'(t);
            end
        end
        busy = steps + 1;
    endfunction

    task automatic pulse(input logic [7:0] mask, input logic [7:0] data);
        @(negedge clk);
        ui_in  = data;
        uio_in = mask;
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic load(input logic [15:0] v);
        pulse(8'h01, v[15:8]);
        pulse(8'h01, v[7:0]);
    endtask

    task automatic wait_done(output int busy_cnt, output bit timed_out);
        busy_cnt  = 0;
        timed_out = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            if (uio_out[6]) begin
                timed_out = 1'b0;
                break;
            end
            if (uio_out[7]) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic read_result(output logic [31:0] r);
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[i*8 +: 8] = uo_out;
            pulse(8'h04, 8'h00);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #12;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uo_out got %h want 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_out got %h want 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'hF0) begin
            errors++;
            $display("FAIL reset_uio_oe got %h want f0", uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_six();
        int        b;
        bit        to;
        logic [7:0] exp_bytes [5] = '{8'h08, 8'h00, 8'h10, 8'h00, 8'h08};
        load(16'h0006);
        pulse(8'h02, 8'h00);
        wait_done(b, to);
        checks++;
        if (to !== 1'b0 || b != 9) begin
            errors++;
            $display("FAIL six_busy got %0d (timeout %0d) want 9", b, to);
        end
        checks++;
        if (uio_out !== 8'h40) begin
            errors++;
            $display("FAIL six_flags got %h want 40", uio_out);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (uo_out !== exp_bytes[i]) begin
                errors++;
                $display("FAIL six_byte%0d got %h want %h", i, uo_out, exp_bytes[i]);
            end
            pulse(8'h04, 8'h00);
        end
        pulse(8'h04, 8'h00);
        pulse(8'h04, 8'h00);
        pulse(8'h04, 8'h00);
    endtask

    task automatic run_check(input logic [15:0] v, input string tag);
        int unsigned es, ep, eb;
        bit          eo;
        int          b;
        bit          to;
        logic [31:0] r;
        ref_model(v, es, ep, eo, eb);
        load(v);
        pulse(8'h02, 8'h00);
        wait_done(b, to);
        checks++;
        if (to !== 1'b0 || b != int'(eb)) begin
            errors++;
            $display("FAIL %s_busy v=%h got %0d (timeout %0d) want %0d", tag, v, b, to, eb);
        end
        checks++;
        if (uio_out !== {1'b0, 1'b1, eo, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL %s_flags v=%h got %h want %h", tag, v, uio_out,
                     {1'b0, 1'b1, eo, 1'b0, 4'b0000});
        end
        read_result(r);
        checks++;
        if (r !== {ep[15:0], es[15:0]}) begin
            errors++;
            $display("FAIL %s_result v=%h got %h want %h", tag, v, r, {ep[15:0], es[15:0]});
        end
    endtask

    task automatic test_table();
        logic [15:0] dirs [4] = '{16'd27, 16'hFFFF, 16'd1, 16'd0};
        logic [31:0] r;
        int          b;
        bit          to;
        foreach (dirs[i]) run_check(dirs[i], "dir");
        load(16'd27);
        pulse(8'h02, 8'h00);
        wait_done(b, to);
        read_result(r);
        checks++;
        if (r !== 32'h2410_006F) begin
            errors++;
            $display("FAIL const27 got %h want 2410006f", r);
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = (i % 2 == 0) ? 16'($urandom_range(1, 3000)) : 16'($urandom_range(0, 65535));
            run_check(v, "rnd");
        end
    endtask

    task automatic test_run_ignores();
        int unsigned es, ep, eb;
        bit          eo;
        int          b;
        bit          to;
        logic [31:0] r;
        ref_model(27, es, ep, eo, eb);
        load(16'd27);
        pulse(8'h02, 8'h00);
        repeat (5) @(negedge clk);
        pulse(8'h01, 8'h99);
        pulse(8'h02, 8'h00);
        checks++;
        if (uio_out[7] !== 1'b1) begin
            errors++;
            $display("FAIL run_still_busy got %b want 1", uio_out[7]);
        end
        wait_done(b, to);
        read_result(r);
        checks++;
        if (to !== 1'b0 || r !== {ep[15:0], es[15:0]}) begin
            errors++;
            $display("FAIL run_ignore_result got %h want %h", r, {ep[15:0], es[15:0]});
        end
        pulse(8'h02, 8'h00);
        wait_done(b, to);
        read_result(r);
        checks++;
        if (to !== 1'b0 || r !== {ep[15:0], es[15:0]}) begin
            errors++;
            $display("FAIL run_ignore_value got %h want %h", r, {ep[15:0], es[15:0]});
        end
    endtask

    task automatic test_wr_start_same();
        int          b;
        bit          to;
        logic [31:0] r;
        do_reset();
        load(16'h0006);
        pulse(8'h03, 8'h05);
        wait_done(b, to);
        read_result(r);
        checks++;
        if (to !== 1'b0 || b != 9 || r !== 32'h0010_0008) begin
            errors++;
            $display("FAIL same_cycle got %h busy %0d want 00100008 busy 9", r, b);
        end
        pulse(8'h02, 8'h00);
        wait_done(b, to);
        read_result(r);
        checks++;
        if (to !== 1'b0 || r !== 32'h0010_0008) begin
            errors++;
            $display("FAIL same_cycle_wr_dropped got %h want 00100008", r);
        end
    endtask

    task automatic test_ena();
        int          b;
        bit          to;
        logic [31:0] r;
        ena = 1'b0;
        pulse(8'h02, 8'h00);
        pulse(8'h01, 8'h77);
        pulse(8'h04, 8'h00);
        checks++;
        if (uio_out !== 8'h40 || uo_out !== 8'h08) begin
            errors++;
            $display("FAIL ena_low got %h/%h want 40/08", uio_out, uo_out);
        end
        @(negedge clk);
        uio_in = 8'h02;
        @(negedge clk);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (uio_out !== 8'h40) begin
            errors++;
            $display("FAIL ena_rise_held got %h want 40", uio_out);
        end
        uio_in = 8'h00;
        pulse(8'h02, 8'h00);
        wait_done(b, to);
        read_result(r);
        checks++;
        if (to !== 1'b0 || r !== 32'h0010_0008) begin
            errors++;
            $display("FAIL ena_value_kept got %h want 00100008", r);
        end
    endtask

    task automatic test_reset_midrun();
        int b;
        bit to;
        load(16'd27);
        pulse(8'h02, 8'h00);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uio_out !== 8'h00 || uo_out !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset got %h/%h want 00/00", uio_out, uo_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse(8'h02, 8'h00);
        wait_done(b, to);
        checks++;
        if (to !== 1'b0 || b != 0 || uio_out !== 8'h60) begin
            errors++;
            $display("FAIL midrun_value_cleared got %h busy %0d want 60 busy 0", uio_out, b);
        end
    endtask

    initial begin
        test_reset();
        test_six();
        test_table();
        test_run_ignores();
        test_wr_start_same();
        test_ena();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
